pipeline_hazard_scoreboard: RTL and testbench

Issue-control scoreboard for the pipelined vector CPU. Sits alongside the decode stage and decides each cycle whether the instruction in decode may enter the ID/EX register, stalling fetch/decode and injecting a bubble into ID/EX on read-after-write hazards. It also squashes decode and ID/EX on a taken branch. There is no forwarding network, so all hazards are resolved by stalling until the producer's writeback completes.

---
 rtl/pipeline_hazard_scoreboard.sv | 61 ++++++
 tb/tb_pipeline_hazard_scoreboard.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_scoreboard.sv
// pipeline_hazard_scoreboard: per-register pending counters that stall decode on RAW
// hazards and squash decode/ID-EX on a taken branch; no forwarding, so stalls last until writeback.
module pipeline_hazard_scoreboard #(
   parameter int NREGS   = 16,
   parameter int ALU_LAT = 3,
   parameter int MEM_LAT = 4,
   parameter int CNTW    = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ValidD,
   input  logic [$clog2(NREGS)-1:0]   RA1D,
   input  logic [$clog2(NREGS)-1:0]   RA2D,
   input  logic                       Use1D,
   input  logic                       Use2D,
   input  logic                       RegWriteD,
   input  logic                       MemtoRegD,
   input  logic [$clog2(NREGS)-1:0]   WA3D,
   input  logic                       BranchTakenE,
   output logic                       StallF,
   output logic                       StallD,
   output logic                       FlushD,
   output logic                       FlushE,
   output logic                       IssueD,
   output logic [NREGS-1:0]           PendingMask,
   output logic [15:0]                StallCount
);
   localparam int AW = $clog2(NREGS);

   logic [CNTW-1:0] cnt [NREGS];
   logic [CNTW-1:0] dec [NREGS];
   logic [CNTW-1:0] lat;
   logic            haz;

   assign haz    = ValidD & ((Use1D & (cnt[RA1D] != '0)) | (Use2D & (cnt[RA2D] != '0)));
   assign lat    = MemtoRegD ? CNTW'(MEM_LAT) : CNTW'(ALU_LAT);
   assign StallF = haz & ~BranchTakenE;
   assign StallD = StallF;
   assign FlushD = BranchTakenE;
   assign FlushE = BranchTakenE | haz;
   assign IssueD = ValidD & ~BranchTakenE & ~haz;

   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         dec[r]         = (cnt[r] == '0) ? '0 : cnt[r] - 1'b1;
         PendingMask[r] = |cnt[r];
      end
   end

   // A new write only ever raises the wait, so WAW cannot shorten an older producer's stall.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
         StallCount <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++)
            cnt[r] <= (IssueD & RegWriteD & (WA3D == AW'(r)) & (dec[r] < lat)) ? lat : dec[r];
         if (StallF && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// tb_pipeline_hazard_scoreboard: directed plus random traffic against a reference scoreboard model,
// with expected outputs queued at drive time and compared when sampled mid-cycle.
module tb_pipeline_hazard_scoreboard;
   logic        clk, reset;
   logic        ValidD, Use1D, Use2D, RegWriteD, MemtoRegD, BranchTakenE;
   logic [3:0]  RA1D, RA2D, WA3D;
   logic        StallF, StallD, FlushD, FlushE, IssueD;
   logic [15:0] PendingMask, StallCount;

   pipeline_hazard_scoreboard dut (
      .clk(clk), .reset(reset), .ValidD(ValidD), .RA1D(RA1D), .RA2D(RA2D),
      .Use1D(Use1D), .Use2D(Use2D), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
      .WA3D(WA3D), .BranchTakenE(BranchTakenE), .StallF(StallF), .StallD(StallD),
      .FlushD(FlushD), .FlushE(FlushE), .IssueD(IssueD), .PendingMask(PendingMask),
      .StallCount(StallCount)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        sf, sd, fd, fe, iss;
      logic [15:0] mask, sc;
   } exp_t;

   exp_t        q[$];
   int          m_cnt [16];
   int          m_sc;
   int          n_chk, n_pass;
   logic        last_issue, last_stall, last_fd, last_fe;
   logic [15:0] last_mask;
   int          stalls, hits;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One decode cycle: drive inputs, queue model expectation, compare mid-cycle, advance model at the falling edge.
   task automatic drive(input logic v, input logic [3:0] a1, input logic u1, input logic [3:0] a2,
                        input logic u2, input logic rw, input logic mr, input logic [3:0] wa, input logic br);
      exp_t e, p;
      logic haz;
      int   d;
      ValidD = v; RA1D = a1; Use1D = u1; RA2D = a2; Use2D = u2;
      RegWriteD = rw; MemtoRegD = mr; WA3D = wa; BranchTakenE = br;
      haz = v && ((u1 && m_cnt[a1] != 0) || (u2 && m_cnt[a2] != 0));
      e.sf = haz && !br; e.sd = haz && !br; e.fd = br; e.fe = br || haz; e.iss = v && !br && !haz;
      for (int r = 0; r < 16; r++) e.mask[r] = (m_cnt[r] != 0);
      e.sc = 16'(m_sc);
      q.push_back(e);
      @(posedge clk); #1;
      p = q.pop_front();
      check("StallF", StallF, p.sf);
      check("StallD", StallD, p.sd);
      check("FlushD", FlushD, p.fd);
      check("FlushE", FlushE, p.fe);
      check("IssueD", IssueD, p.iss);
      check("PendingMask", PendingMask, p.mask);
      check("StallCount", StallCount, p.sc);
      last_issue = IssueD; last_stall = StallD; last_fd = FlushD; last_fe = FlushE; last_mask = PendingMask;
      @(negedge clk);
      for (int r = 0; r < 16; r++) begin
         d = (m_cnt[r] == 0) ? 0 : m_cnt[r] - 1;
         if (p.iss && rw && wa == 4'(r)) m_cnt[r] = (d > (mr ? 4 : 3)) ? d : (mr ? 4 : 3);
         else m_cnt[r] = d;
      end
      if (p.sf && m_sc != 16'hFFFF) m_sc++;
      #1;
   endtask

   task automatic hold(input logic [3:0] a1, input logic u1, input logic [3:0] a2, input logic u2,
                       input int w, output int st, output int mh);
      st = 0; mh = 0;
      for (int k = 0; k < 20; k++) begin
         drive(1, a1, u1, a2, u2, 0, 0, 0, 0);
         if (last_mask[w]) mh++;
         if (last_issue) break;
         st++;
      end
   endtask

   initial begin
      n_chk = 0; n_pass = 0; m_sc = 0;
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      reset = 0; ValidD = 1; RA1D = 0; RA2D = 0; Use1D = 0; Use2D = 0;
      RegWriteD = 0; MemtoRegD = 0; WA3D = 0; BranchTakenE = 1;
      #2;
      check("rst_flushd", FlushD, 1);
      check("rst_issue_br", IssueD, 0);
      BranchTakenE = 0; #1;
      check("rst_issue", IssueD, 1);
      check("rst_stalld", StallD, 0);
      check("rst_flushe", FlushE, 0);
      check("rst_mask", PendingMask, 0);
      check("rst_sc", StallCount, 0);
      ValidD = 0; #4; reset = 1;
      @(negedge clk); #1;

      drive(1, 0, 0, 0, 0, 1, 0, 4, 0);
      hold(4, 1, 0, 0, 4, stalls, hits);
      check("alu_stalls", stalls, 3);
      check("alu_sc", StallCount, 3);

      drive(1, 0, 0, 0, 0, 1, 1, 2, 0);
      hold(0, 0, 2, 1, 2, stalls, hits);
      check("load_stalls", stalls, 4);
      check("load_mask_edges", hits, 4);
      check("load_sc", StallCount, 7);

      drive(1, 0, 0, 0, 0, 1, 1, 7, 0);
      drive(1, 0, 0, 0, 0, 1, 0, 7, 0);
      hold(7, 1, 0, 0, 7, stalls, hits);
      check("waw_stalls", stalls, 3);

      drive(1, 0, 0, 0, 0, 1, 0, 9, 0);
      drive(1, 9, 1, 0, 0, 0, 0, 0, 1);
      check("br_flushd", last_fd, 1);
      check("br_flushe", last_fe, 1);
      check("br_stalld", last_stall, 0);
      check("br_issue", last_issue, 0);
      check("br_sc", StallCount, 10);
      hold(9, 1, 0, 0, 9, stalls, hits);
      check("br_after_stalls", stalls, 2);

      drive(1, 0, 0, 0, 0, 1, 0, 4, 0);
      drive(1, 1, 1, 4, 0, 0, 0, 0, 0);
      check("unused_src_issue", last_issue, 1);
      check("unused_src_stall", last_stall, 0);

      for (int k = 0; k < 300; k++)
         drive(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
      for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

      drive(1, 0, 0, 0, 0, 1, 0, 5, 0);
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
      ValidD = 1; RA1D = 5; Use1D = 1; RA2D = 0; Use2D = 0; RegWriteD = 0; MemtoRegD = 0; BranchTakenE = 0;
      @(posedge clk); #1;
      check("mid_stall", StallD, 1);
      check("mid_mask5", PendingMask[5], 1);
      reset = 0; #1;
      check("mid_rst_mask", PendingMask, 0);
      check("mid_rst_stall", StallD, 0);
      check("mid_rst_issue", IssueD, 1);
      ValidD = 0; #1; reset = 1;
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      m_sc = 0;
      @(negedge clk); #1;
      check("post_rst_sc", StallCount, 0);
      check("post_rst_mask", PendingMask, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
